text_cursor_ctrl: RTL

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

---
 rtl/text_cursor_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/text_cursor_ctrl.sv
// UART-fed text cursor controller: decodes printable/control bytes into text RAM writes.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module text_cursor_ctrl #(
    parameter int COLS      = 32,
    parameter int ROWS      = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic [7:0]              wr_data,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic                    busy,
    output logic                    drop_err,
    output logic                    cursor_vis
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = RW + CW;
    localparam logic [PW:0] CELLS = (PW+1)'(ROWS * COLS);

    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;

    // Row-major linear position; power-of-two geometry makes +/-1 wrap for free.
    logic [PW-1:0] pos, pos_inc, pos_dec;
    logic [PW:0]   clr_cnt;
    logic          printable;

    assign pos       = {cur_row, cur_col};
    assign pos_inc   = pos + PW'(1);
    assign pos_dec   = pos - PW'(1);
    assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_row  <= '0;
            cur_col  <= '0;
            wr_en    <= 1'b0;
            wr_row   <= '0;
            wr_col   <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            drop_err <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: if (rx_valid) begin
                    if (printable) begin
                        wr_en              <= 1'b1;
                        wr_row             <= cur_row;
                        wr_col             <= cur_col;
                        wr_data            <= rx_data;
                        {cur_row, cur_col} <= pos_inc;
                    end else begin
                        case (rx_data)
                            8'h0D: cur_col <= '0;
                            8'h0A: cur_row <= cur_row + RW'(1);
                            8'h08: if (pos != '0) begin
                                {cur_row, cur_col} <= pos_dec;
                                {wr_row, wr_col}   <= pos_dec;
                                wr_data            <= 8'h20;
                                wr_en              <= 1'b1;
                            end
                            8'h0C: begin
                                // Cell 0 is written on entry so the sweep is exactly ROWS*COLS cycles.
                                state   <= CLEAR;
                                busy    <= 1'b1;
                                wr_en   <= 1'b1;
                                wr_row  <= '0;
                                wr_col  <= '0;
                                wr_data <= 8'h20;
                                clr_cnt <= (PW+1)'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    if (rx_valid) drop_err <= 1'b1;
                    if (clr_cnt == CELLS) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cur_row <= '0;
                        cur_col <= '0;
                    end else begin
                        wr_en            <= 1'b1;
                        {wr_row, wr_col} <= clr_cnt[PW-1:0];
                        wr_data          <= 8'h20;
                        clr_cnt          <= clr_cnt + (PW+1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt;
    logic [PW-1:0] last_pos;

    // A move restarts a full visible phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt  <= '0;
            cursor_vis <= 1'b1;
            last_pos   <= '0;
        end else begin
            last_pos <= pos;
            if (pos != last_pos) begin
                blink_cnt  <= '0;
                cursor_vis <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt  <= '0;
                cursor_vis <= ~cursor_vis;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end
`else
    assign cursor_vis = 1'b1;
`endif

endmodule
